flush_reload_engine: RTL and testbench

- Synthesizable flush+reload sequencer that drives the partitioned cache's CPU request port on behalf of one protection domain.
- Runs a flush phase, then a victim window, then a reload phase over a programmable table of NUM_TARGETS line addresses.
- Measures per-target reload latency and classifies each target as hit or miss against a threshold.
- Used to characterise DAWG way-partition isolation in hardware, with configurable target count, widths and run modes.

---
 rtl/flush_reload_engine_if.sv | 25 ++
 rtl/flush_reload_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_flush_reload_engine.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flush_reload_engine_if.sv
// CPU request/response port between the flush+reload engine and the partitioned cache.
// master = engine side, slave = cache side.
interface flush_reload_engine_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DOM_W  = 2
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_rw;
    logic              req_flush;
    logic [DOM_W-1:0]  req_domain_id;
    logic              res_ready;

    modport master (
        output req_valid, req_addr, req_data, req_rw, req_flush, req_domain_id,
        input  res_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_rw, req_flush, req_domain_id,
        output res_ready
    );
endinterface

// File: rtl/flush_reload_engine.sv
// Flush+reload sequencer: flushes a table of target lines, waits a victim window,
// reloads them and classifies each reload latency as hit or miss.
module flush_reload_engine #(
    parameter int unsigned NUM_TARGETS = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned DOM_W       = 2,
    parameter int unsigned LAT_W       = 8,
    parameter int unsigned TIMEOUT     = 200,
    localparam int unsigned IDX_W      = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tgt_we,
    input  logic [IDX_W-1:0]       tgt_idx,
    input  logic [ADDR_W-1:0]      tgt_addr,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [DOM_W-1:0]       domain_id,
    input  logic [15:0]            window,
    input  logic [LAT_W-1:0]       threshold,
    flush_reload_engine_if.master  cache,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_TARGETS-1:0] hit_map,
    output logic [LAT_W-1:0]       lat_rdata,
    output logic                   timeout_err
);

    localparam int unsigned     DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TARGETS - 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = '1;
    localparam logic [LAT_W-1:0] TMO_CNT  = LAT_W'(TIMEOUT);
    localparam logic [1:0]       MODE_RL  = 2'b01;
    localparam logic [1:0]       MODE_FL  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FL_ISSUE,
        S_FL_WAIT,
        S_WINDOW,
        S_RL_ISSUE,
        S_RL_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_nx;

    logic [IDX_W-1:0]       idx_q, idx_nx;
    logic [1:0]             mode_q;
    logic [15:0]            win_q;
    logic [15:0]            win_cnt_q;
    logic [LAT_W-1:0]       thr_q;
    logic [LAT_W-1:0]       cnt_q;
    logic [ADDR_W-1:0]      tgt_tbl [DEPTH];
    logic [LAT_W-1:0]       lat_tbl [DEPTH];
    logic [NUM_TARGETS-1:0] hit_map_q;
    logic                   timeout_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   req_valid_q;
    logic [ADDR_W-1:0]      req_addr_q;
    logic                   req_flush_q;
    logic [DOM_W-1:0]       req_dom_q;

    logic             start_acc;
    logic             in_wait;
    logic             wait_tmo;
    logic             wait_end;
    logic             lat_we;
    logic [LAT_W-1:0] lat_val;
    logic             hit_val;
    logic             issue_nx;

    // A response only counts while a request is outstanding
    assign in_wait  = (state_q == S_FL_WAIT) || (state_q == S_RL_WAIT);
    assign wait_tmo = in_wait && !cache.res_ready && (cnt_q == TMO_CNT);
    assign wait_end = in_wait && (cache.res_ready || wait_tmo);
    assign issue_nx = (state_nx == S_FL_ISSUE) || (state_nx == S_RL_ISSUE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nx  = state_q;
        idx_nx    = idx_q;
        start_acc = 1'b0;
        lat_we    = 1'b0;
        lat_val   = '0;
        hit_val   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    idx_nx    = '0;
                    state_nx  = (mode == MODE_RL) ? S_RL_ISSUE : S_FL_ISSUE;
                end
            end
            S_FL_ISSUE: state_nx = S_FL_WAIT;
            S_FL_WAIT: begin
                if (wait_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_nx = (mode_q == MODE_FL) ? S_DONE : S_WINDOW;
                    end else begin
                        idx_nx   = idx_q + IDX_W'(1);
                        state_nx = S_FL_ISSUE;
                    end
                end
            end
            S_WINDOW: begin
                if (win_cnt_q >= win_q) begin
                    idx_nx   = '0;
                    state_nx = S_RL_ISSUE;
                end
            end
            S_RL_ISSUE: state_nx = S_RL_WAIT;
            S_RL_WAIT: begin
                if (wait_end) begin
                    lat_we  = 1'b1;
                    lat_val = wait_tmo ? LAT_MAX : cnt_q;
                    hit_val = !wait_tmo && (cnt_q <= thr_q);
                    if (idx_q == LAST_IDX) begin
                        state_nx = S_DONE;
                    end else begin
                        idx_nx   = idx_q + IDX_W'(1);
                        state_nx = S_RL_ISSUE;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath, tables and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            mode_q      <= '0;
            win_q       <= '0;
            win_cnt_q   <= '0;
            thr_q       <= '0;
            cnt_q       <= '0;
            hit_map_q   <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_flush_q <= 1'b0;
            req_dom_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tgt_tbl[i] <= '0;
                lat_tbl[i] <= '0;
            end
        end else begin
            idx_q <= idx_nx;

            if ((state_q == S_IDLE) && tgt_we) begin
                tgt_tbl[tgt_idx] <= tgt_addr;
            end

            if (start_acc) begin
                mode_q    <= mode;
                win_q     <= window;
                thr_q     <= threshold;
                req_dom_q <= domain_id;
                hit_map_q <= '0;
                timeout_q <= 1'b0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    lat_tbl[i] <= '0;
                end
            end

            // Shared latency / timeout counter: 1 in the first wait cycle
            if ((state_q == S_FL_ISSUE) || (state_q == S_RL_ISSUE)) begin
                cnt_q <= LAT_W'(1);
            end else if (in_wait && (cnt_q != LAT_MAX)) begin
                cnt_q <= cnt_q + LAT_W'(1);
            end

            if ((state_nx == S_WINDOW) && (state_q != S_WINDOW)) begin
                win_cnt_q <= 16'd1;
            end else if (state_q == S_WINDOW) begin
                win_cnt_q <= win_cnt_q + 16'd1;
            end

            if (lat_we) begin
                lat_tbl[idx_q]   <= lat_val;
                hit_map_q[idx_q] <= hit_val;
            end

            if (wait_tmo) begin
                timeout_q <= 1'b1;
            end

            req_valid_q <= issue_nx;
            if (issue_nx) begin
                req_addr_q <= tgt_tbl[idx_nx];
            end
            req_flush_q <= (state_nx == S_FL_ISSUE) || (state_nx == S_FL_WAIT);

            busy_q <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done_q <= (state_nx == S_DONE);
        end
    end

    assign cache.req_valid     = req_valid_q;
    assign cache.req_addr      = req_addr_q;
    assign cache.req_data      = '0;
    assign cache.req_rw        = 1'b0;
    assign cache.req_flush     = req_flush_q;
    assign cache.req_domain_id = req_dom_q;

    assign busy        = busy_q;
    assign done        = done_q;
    assign hit_map     = hit_map_q;
    assign timeout_err = timeout_q;
    assign lat_rdata   = lat_tbl[tgt_idx];

endmodule

// File: tb/tb_flush_reload_engine.sv
// Self-checking bench for flush_reload_engine: a delay-programmable cache responder
// plus a per-run reference model of strobes, latencies, hits and timeouts.
module tb_flush_reload_engine;

    localparam int N       = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int DOM_W   = 2;
    localparam int LAT_W   = 8;
    localparam int TIMEOUT = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              tgt_we;
    logic [1:0]        tgt_idx;
    logic [ADDR_W-1:0] tgt_addr;
    logic              start;
    logic [1:0]        mode;
    logic [DOM_W-1:0]  domain_id;
    logic [15:0]       window;
    logic [LAT_W-1:0]  threshold;
    logic              busy;
    logic              done;
    logic [N-1:0]      hit_map;
    logic [LAT_W-1:0]  lat_rdata;
    logic              timeout_err;

    flush_reload_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DOM_W(DOM_W)) bus ();

    flush_reload_engine #(
        .NUM_TARGETS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DOM_W(DOM_W),
        .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .tgt_we(tgt_we), .tgt_idx(tgt_idx), .tgt_addr(tgt_addr),
        .start(start), .mode(mode), .domain_id(domain_id), .window(window),
        .threshold(threshold), .cache(bus), .busy(busy), .done(done),
        .hit_map(hit_map), .lat_rdata(lat_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Bench view of the target table and per-slot response delays (-1 = never respond)
    logic [ADDR_W-1:0] tbl [N];
    int fl_delay [N];
    int rl_delay [N];

    // Strobe / response log filled by the responder
    int                st_cyc   [$];
    logic [ADDR_W-1:0] st_addr  [$];
    bit                st_flush [$];
    logic [DOM_W-1:0]  st_dom   [$];
    bit                st_bad   [$];
    int                resp_cyc [$];
    int fl_seen, rl_seen, done_cnt, done_busy_bad, start_cyc;

    // Reference model results
    logic [N-1:0]     exp_hit;
    logic [LAT_W-1:0] exp_lat [N];
    bit               exp_to;
    int               exp_fl, exp_rl;
    logic [DOM_W-1:0] exp_dom;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Cache responder: raises res_ready for one cycle, d cycles after each strobe
    initial begin
        int cd;
        int d;
        cd = -1;
        bus.res_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.res_ready = 1'b0;
            if (rst) begin
                cd = -1;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.res_ready = 1'b1;
                        resp_cyc.push_back(cyc);
                        cd = -1;
                    end
                end
                if (bus.req_valid) begin
                    st_cyc.push_back(cyc);
                    st_addr.push_back(bus.req_addr);
                    st_flush.push_back(bus.req_flush);
                    st_dom.push_back(bus.req_domain_id);
                    st_bad.push_back((bus.req_data != '0) || bus.req_rw);
                    if (bus.req_flush) begin
                        d = fl_delay[fl_seen % N];
                        fl_seen++;
                    end else begin
                        d = rl_delay[rl_seen % N];
                        rl_seen++;
                    end
                    cd = d;
                end
                if (done) begin
                    done_cnt++;
                    if (busy) done_busy_bad++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim time exceeded, required run to finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        st_cyc.delete(); st_addr.delete(); st_flush.delete();
        st_dom.delete(); st_bad.delete(); resp_cyc.delete();
        fl_seen = 0; rl_seen = 0; done_cnt = 0; done_busy_bad = 0;
    endtask

    task automatic load_table();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            tgt_we = 1'b1; tgt_idx = 2'(i); tgt_addr = tbl[i];
        end
        @(negedge clk);
        tgt_we = 1'b0;
    endtask

    task automatic set_delays(input int f, input int r0, input int r1, input int r2, input int r3);
        for (int i = 0; i < N; i++) fl_delay[i] = f;
        rl_delay[0] = r0; rl_delay[1] = r1; rl_delay[2] = r2; rl_delay[3] = r3;
    endtask

    // Expected outcome from the run rules: latency is the response delay, or saturated on timeout
    task automatic model_job(input logic [1:0] m, input logic [7:0] th);
        bit do_fl;
        bit do_rl;
        do_fl = (m != 2'b01);
        do_rl = (m != 2'b10);
        exp_fl = do_fl ? N : 0;
        exp_rl = do_rl ? N : 0;
        exp_to = 1'b0;
        exp_hit = '0;
        for (int i = 0; i < N; i++) begin
            if (do_fl && fl_delay[i] < 0) exp_to = 1'b1;
            exp_lat[i] = '0;
            if (do_rl) begin
                if (rl_delay[i] < 0) begin
                    exp_lat[i] = 8'd255;
                    exp_to = 1'b1;
                end else begin
                    exp_lat[i] = 8'(rl_delay[i]);
                    exp_hit[i] = (rl_delay[i] <= int'(th));
                end
            end
        end
    endtask

    task automatic run_job(input logic [1:0] m, input logic [1:0] d, input logic [15:0] w,
                           input logic [7:0] th, output bit finished);
        clear_log();
        model_job(m, th);
        exp_dom = d;
        @(negedge clk);
        mode = m; domain_id = d; window = w; threshold = th; start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) finished = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    // Compares a completed run against the reference model
    task automatic verify_job(input string tag, input bit finished);
        logic [LAT_W-1:0] lat;
        int total;
        total = exp_fl + exp_rl;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s done_wait: no done pulse within budget, required one", tag);
        end
        checks++;
        if (done_cnt != 1 || done_busy_bad != 0) begin
            errors++;
            $display("FAIL %s done_pulse: got %0d pulses (%0d with busy), required 1 (0)", tag, done_cnt, done_busy_bad);
        end
        checks++;
        if (st_cyc.size() != total) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d, required %0d", tag, st_cyc.size(), total);
        end
        for (int k = 0; k < total && k < st_cyc.size(); k++) begin
            int  slot;
            bit  fl;
            fl   = (k < exp_fl);
            slot = fl ? k : k - exp_fl;
            checks++;
            if (st_addr[k] !== tbl[slot] || st_flush[k] !== fl || st_dom[k] !== exp_dom || st_bad[k]) begin
                errors++;
                $display("FAIL %s strobe%0d: got addr %h flush %0b dom %0d bad %0b, required addr %h flush %0b dom %0d bad 0",
                         tag, k, st_addr[k], st_flush[k], st_dom[k], st_bad[k], tbl[slot], fl, exp_dom);
            end
            if (k > 0) begin
                checks++;
                if (st_cyc[k] - st_cyc[k-1] < 2) begin
                    errors++;
                    $display("FAIL %s strobe_spacing%0d: got %0d cycles, required >= 2", tag, k, st_cyc[k] - st_cyc[k-1]);
                end
            end
        end
        checks++;
        if (hit_map !== exp_hit) begin
            errors++;
            $display("FAIL %s hit_map: got %b, required %b", tag, hit_map, exp_hit);
        end
        checks++;
        if (timeout_err !== exp_to) begin
            errors++;
            $display("FAIL %s timeout_err: got %b, required %b", tag, timeout_err, exp_to);
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            tgt_idx = 2'(i);
            #1;
            lat = lat_rdata;
            checks++;
            if (lat !== exp_lat[i]) begin
                errors++;
                $display("FAIL %s lat%0d: got %0d, required %0d", tag, i, lat, exp_lat[i]);
            end
        end
    endtask

    // Reload phase begins 1 + max(window,1) cycles after the last flush response
    task automatic check_gap(input string tag, input int w);
        int want;
        want = 1 + ((w == 0) ? 1 : w);
        checks++;
        if (resp_cyc.size() < exp_fl || st_cyc.size() <= exp_fl) begin
            errors++;
            $display("FAIL %s window_gap: log too short (%0d resp, %0d strobes)", tag, resp_cyc.size(), st_cyc.size());
        end else if (st_cyc[exp_fl] - resp_cyc[exp_fl-1] != want) begin
            errors++;
            $display("FAIL %s window_gap: got %0d, required %0d", tag, st_cyc[exp_fl] - resp_cyc[exp_fl-1], want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hit_map !== '0 ||
            timeout_err !== 1'b0 || bus.req_flush !== 1'b0 || bus.req_addr !== '0 || bus.req_domain_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid %b busy %b done %b hit %b to %b flush %b addr %h dom %0d, required all 0",
                     bus.req_valid, busy, done, hit_map, timeout_err, bus.req_flush, bus.req_addr, bus.req_domain_id);
        end
        for (int i = 0; i < N; i++) begin
            tgt_idx = 2'(i);
            #1;
            checks++;
            if (lat_rdata !== '0) begin
                errors++;
                $display("FAIL reset_lat%0d: got %0d, required 0", i, lat_rdata);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_flush_reload();
        bit fin;
        tbl[0] = 32'h1111_0010; tbl[1] = 32'h3333_0010; tbl[2] = 32'h5555_0010; tbl[3] = 32'h7777_0010;
        load_table();
        set_delays(1, 2, 2, 2, 2);
        run_job(2'b00, 2'd3, 16'd5, 8'd3, fin);
        verify_job("flush_reload", fin);
        check_gap("flush_reload", 5);
    endtask

    task automatic test_slow_reload();
        bit fin;
        set_delays(1, 2, 8, 2, 8);
        run_job(2'b00, 2'd3, 16'd5, 8'd3, fin);
        verify_job("slow_reload", fin);
    endtask

    task automatic test_reload_only();
        bit fin;
        set_delays(1, 2, 3, 4, 5);
        run_job(2'b01, 2'd2, 16'd9, 8'd3, fin);
        verify_job("reload_only", fin);
        checks++;
        if (st_cyc.size() == 0 || st_cyc[0] != start_cyc + 1 || st_flush[0] !== 1'b0) begin
            errors++;
            $display("FAIL reload_only first_strobe: got %0d strobes, first at +%0d, required +1 with flush 0",
                     st_cyc.size(), (st_cyc.size() > 0) ? st_cyc[0] - start_cyc : -1);
        end
    endtask

    task automatic test_flush_only();
        bit fin;
        set_delays(2, 1, 1, 1, 1);
        run_job(2'b10, 2'd1, 16'd5, 8'd3, fin);
        verify_job("flush_only", fin);
    endtask

    task automatic test_timeout();
        bit fin;
        set_delays(1, 2, 2, -1, 3);
        run_job(2'b00, 2'd3, 16'd5, 8'd3, fin);
        verify_job("timeout", fin);
    endtask

    task automatic test_random();
        bit fin;
        logic [1:0]  m;
        logic [15:0] w;
        logic [7:0]  th;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) begin
                tbl[i] = $urandom;
                fl_delay[i] = $urandom_range(6, 1);
                rl_delay[i] = $urandom_range(20, 1);
            end
            load_table();
            m  = 2'($urandom_range(3, 0));
            w  = 16'($urandom_range(20, 0));
            th = 8'($urandom_range(15, 1));
            run_job(m, 2'($urandom_range(3, 0)), w, th, fin);
            verify_job($sformatf("random%0d", it), fin);
            if (m != 2'b01 && m != 2'b10) check_gap($sformatf("random%0d", it), int'(w));
        end
    endtask

    task automatic test_busy_abort();
        bit fin;
        logic [ADDR_W-1:0] lat_chk;
        tbl[0] = 32'hA000_0040; tbl[1] = 32'hA000_0080; tbl[2] = 32'hA000_00C0; tbl[3] = 32'hA000_0100;
        load_table();
        set_delays(3, 3, 3, 3, 3);
        clear_log();
        model_job(2'b00, 8'd5);
        exp_dom = 2'd1;
        @(negedge clk);
        mode = 2'b00; domain_id = 2'd1; window = 16'd2; threshold = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && fl_seen < 1; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_run: got %b, required 1", busy);
        end
        start = 1'b1; mode = 2'b01; tgt_we = 1'b1; tgt_idx = 2'd3; tgt_addr = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; tgt_we = 1'b0; mode = 2'b00;
        fin = 1'b0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) fin = 1'b1;
        end
        repeat (3) @(negedge clk);
        verify_job("busy_ignore", fin);

        // Abort with reset while a reload is outstanding
        set_delays(1, -1, -1, -1, -1);
        clear_log();
        @(negedge clk);
        mode = 2'b00; domain_id = 2'd2; window = 16'd1; threshold = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && rl_seen < 1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rl_seen != 1) begin
            errors++;
            $display("FAIL abort_setup: got busy %b reloads %0d, required busy 1 reloads 1", busy, rl_seen);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_next_cycle: got valid %b busy %b, required 0 0", bus.req_valid, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (hit_map !== '0 || timeout_err !== 1'b0 || done !== 1'b0 || bus.req_addr !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got hit %b to %b done %b addr %h, required 0", hit_map, timeout_err, done, bus.req_addr);
        end
        tgt_idx = 2'd0;
        #1;
        lat_chk = ADDR_W'(lat_rdata);
        checks++;
        if (lat_chk !== '0) begin
            errors++;
            $display("FAIL abort_lat0: got %0d, required 0", lat_chk);
        end
        // Table must read back as cleared through the strobe addresses
        for (int i = 0; i < N; i++) tbl[i] = '0;
        set_delays(1, 1, 1, 1, 1);
        run_job(2'b10, 2'd0, 16'd0, 8'd0, fin);
        verify_job("after_abort", fin);
    endtask

    initial begin
        rst = 1'b1; tgt_we = 1'b0; tgt_idx = '0; tgt_addr = '0; start = 1'b0;
        mode = 2'b00; domain_id = '0; window = '0; threshold = '0;
        for (int i = 0; i < N; i++) begin
            tbl[i] = '0; fl_delay[i] = 1; rl_delay[i] = 1;
        end
        clear_log();
        test_reset();
        test_flush_reload();
        test_slow_reload();
        test_reload_only();
        test_flush_only();
        test_timeout();
        test_random();
        test_busy_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
